hsv_core_commit_writeback: RTL

//  Completion end of the issue->exec path. Collects results from the ALU, branch, ctrl_status
//  and mem units, picks one per cycle round-robin, and writes it to the register file.

---
 rtl/hsv_core_pkg.sv | 42 ++++
 rtl/hsv_core_commit_rr_arbiter.sv | 57 +++++
 rtl/hsv_core_commit_writeback.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared commit-path types: result beat layout, unit ordering and the rd -> scoreboard mask helper.
package hsv_core_pkg;

    typedef logic [4:0]  reg_addr;
    typedef logic [31:0] word;
    typedef logic [31:0] reg_mask;

    localparam int NUM_COMMIT_UNITS = 4;

    typedef enum logic [1:0] {
        COMMIT_ALU         = 2'd0,
        COMMIT_BRANCH      = 2'd1,
        COMMIT_CTRL_STATUS = 2'd2,
        COMMIT_MEM         = 2'd3
    } commit_unit_e;

    typedef struct packed {
        reg_addr rd;
        word     value;
        word     pc;
        logic    redirect;
        word     target;
    } commit_data_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } commit_state_e;

    // x0 is hardwired, so it never owns a pending-write bit.
    function automatic reg_mask rd_onehot(input reg_addr rd);
        reg_mask m;
        m = 32'd0;
        if (rd != 5'd0) begin
            m[rd] = 1'b1;
        end else begin
            m = 32'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/hsv_core_commit_rr_arbiter.sv
// N-way round-robin arbiter; the pointer names the highest-priority requester for the next grant.
module hsv_core_commit_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic         ptr_rst,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_s;
    logic          found_s;

    // Scan requesters starting at the pointer and take the first one found.
    always_comb begin
        grant   = '0;
        win_s   = '0;
        found_s = 1'b0;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (int'(ptr_q) + off) % N;
            if (!found_s && req[idx]) begin
                grant[idx] = 1'b1;
                win_s      = PW'(idx);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves past the winner; holds when nothing was granted.
    always_comb begin
        if (ptr_rst) begin
            ptr_d = '0;
        end else if (advance && found_s) begin
            ptr_d = PW'((int'(win_s) + 1) % N);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hsv_core_commit_writeback.sv
// Commit/writeback: round-robin pick of unit results, regfile write, scoreboard clear and timed flush.
// Optional retired-instruction counter enabled by defining HSV_COMMIT_RETIRE_CNT_EN.
module hsv_core_commit_writeback
    import hsv_core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk_core,
    input  logic         rst_core,
    input  logic         alu_valid_i,
    output logic         alu_ready_o,
    input  commit_data_t alu_result,
    input  logic         branch_valid_i,
    output logic         branch_ready_o,
    input  commit_data_t branch_result,
    input  logic         ctrl_status_valid_i,
    output logic         ctrl_status_ready_o,
    input  commit_data_t ctrl_status_result,
    input  logic         mem_valid_i,
    output logic         mem_ready_o,
    input  commit_data_t mem_result,
    output logic         wr_en,
    output logic [4:0]   wr_addr,
    output logic [31:0]  wr_data,
    output logic [31:0]  clear_mask,
    output logic         flush_req,
    output logic [31:0]  flush_pc
`ifdef HSV_COMMIT_RETIRE_CNT_EN
    ,
    output logic [63:0]  retired_count
`endif
);

    commit_state_e                state_q;
    logic [3:0]                   cnt_q;
    logic [NUM_COMMIT_UNITS-1:0]  valid_s;
    logic [NUM_COMMIT_UNITS-1:0]  grant_s;
    logic [NUM_COMMIT_UNITS-1:0]  ready_s;
    commit_data_t                 res_s [NUM_COMMIT_UNITS];
    commit_data_t                 win_s;
    logic                         accept_run_s;
    logic                         unused_pc_s;

    assign valid_s = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};
    assign res_s[COMMIT_ALU]         = alu_result;
    assign res_s[COMMIT_BRANCH]      = branch_result;
    assign res_s[COMMIT_CTRL_STATUS] = ctrl_status_result;
    assign res_s[COMMIT_MEM]         = mem_result;

    hsv_core_commit_rr_arbiter #(.N(NUM_COMMIT_UNITS)) u_arb (
        .clk     (clk_core),
        .rst     (rst_core),
        .req     (valid_s),
        .advance (accept_run_s),
        .ptr_rst (state_q == ST_FLUSH),
        .grant   (grant_s)
    );

    assign accept_run_s = (state_q == ST_RUN) && (|grant_s);

    // FLUSH drains every unit so stale results cannot wedge their producers.
    always_comb begin
        if (rst_core) begin
            ready_s = '0;
        end else if (state_q == ST_FLUSH) begin
            ready_s = '1;
        end else begin
            ready_s = grant_s;
        end
    end

    assign alu_ready_o         = ready_s[COMMIT_ALU];
    assign branch_ready_o      = ready_s[COMMIT_BRANCH];
    assign ctrl_status_ready_o = ready_s[COMMIT_CTRL_STATUS];
    assign mem_ready_o         = ready_s[COMMIT_MEM];

    // Select the granted beat.
    always_comb begin
        win_s = '0;
        for (int i = 0; i < NUM_COMMIT_UNITS; i++) begin
            if (grant_s[i]) begin
                win_s = res_s[i];
            end else begin
                win_s = win_s;
            end
        end
    end

    assign unused_pc_s = ^win_s.pc;

    // RUN/FLUSH state machine with registered writeback and flush outputs.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 32'd0;
            clear_mask <= 32'd0;
            flush_req  <= 1'b0;
            flush_pc   <= 32'd0;
        end else begin
            wr_en      <= 1'b0;
            clear_mask <= 32'd0;
            case (state_q)
                ST_RUN: begin
                    if (accept_run_s) begin
                        wr_en      <= (win_s.rd != 5'd0);
                        wr_addr    <= win_s.rd;
                        wr_data    <= win_s.value;
                        clear_mask <= rd_onehot(win_s.rd);
                        if (win_s.redirect) begin
                            state_q   <= ST_FLUSH;
                            flush_req <= 1'b1;
                            flush_pc  <= win_s.target;
                            cnt_q     <= 4'(FLUSH_CYCLES - 1);
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= ST_RUN;
                        flush_req <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef HSV_COMMIT_RETIRE_CNT_EN
    // Count beats that actually retired; flushed beats never do.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            retired_count <= 64'd0;
        end else if (accept_run_s) begin
            retired_count <= retired_count + 64'd1;
        end else begin
            retired_count <= retired_count;
        end
    end
`endif

endmodule
